// File: rtl/memory_responder.sv
// Dual-port word memory answering the CPU instruction and data ports over one shared
// array, with a fixed access latency and a one-cycle ready strobe per port.
module memory_responder #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_readM,
    input  logic                 i_writeM,
    input  logic [WORD_SIZE-1:0] i_address,
    inout  wire  [WORD_SIZE-1:0] i_data,
    output logic                 i_ready,
    input  logic                 d_readM,
    input  logic                 d_writeM,
    input  logic [WORD_SIZE-1:0] d_address,
    inout  wire  [WORD_SIZE-1:0] d_data,
    output logic                 d_ready,
    output logic [WORD_SIZE-1:0] num_reads,
    output logic [WORD_SIZE-1:0] num_writes
);

    localparam int         DEPTH = 1 << ADDR_BITS;
    localparam logic [3:0] LAT   = 4'(LATENCY);

    typedef enum logic [1:0] {IDLE, BUSY, READY} state_e;

    logic [WORD_SIZE-1:0] mem [DEPTH];

    state_e               state_q   [2];
    logic [3:0]           cnt_q     [2];
    logic [ADDR_BITS-1:0] addr_q    [2];
    logic                 isWrite_q [2];
    logic [WORD_SIZE-1:0] wrData_q  [2];
    logic [WORD_SIZE-1:0] rdData_q  [2];
    logic [WORD_SIZE-1:0] numReads_q;
    logic [WORD_SIZE-1:0] numWrites_q;

    logic                 reqRead    [2];
    logic                 reqWrite   [2];
    logic [ADDR_BITS-1:0] reqAddr    [2];
    logic [WORD_SIZE-1:0] reqData    [2];
    logic                 accessEn   [2];
    logic                 accessWr   [2];
    logic [ADDR_BITS-1:0] accessAddr [2];
    logic [WORD_SIZE-1:0] accessData [2];
    logic [1:0]           readInc;
    logic [1:0]           writeInc;
    logic                 unusedAddrHi;

    assign reqRead[0]  = i_readM;
    assign reqWrite[0] = i_writeM;
    assign reqAddr[0]  = i_address[ADDR_BITS-1:0];
    assign reqData[0]  = i_data;
    assign reqRead[1]  = d_readM;
    assign reqWrite[1] = d_writeM;
    assign reqAddr[1]  = d_address[ADDR_BITS-1:0];
    assign reqData[1]  = d_data;

    assign unusedAddrHi = ^{i_address[WORD_SIZE-1:ADDR_BITS], d_address[WORD_SIZE-1:ADDR_BITS]};

    // With zero latency the access uses the live request at the edge that accepts it
    always_comb begin
        readInc  = '0;
        writeInc = '0;
        for (int p = 0; p < 2; p++) begin
            if (state_q[p] == IDLE) begin
                accessEn[p]   = reset_n && (LAT == 4'd0) && (reqRead[p] || reqWrite[p]);
                accessWr[p]   = reqWrite[p];
                accessAddr[p] = reqAddr[p];
                accessData[p] = reqData[p];
            end else begin
                accessEn[p]   = reset_n && (state_q[p] == BUSY) && (cnt_q[p] == 4'd1);
                accessWr[p]   = isWrite_q[p];
                accessAddr[p] = addr_q[p];
                accessData[p] = wrData_q[p];
            end
            if (accessEn[p]) begin
                if (accessWr[p]) writeInc = writeInc + 2'd1;
                else             readInc  = readInc + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int p = 0; p < 2; p++) begin
                state_q[p]   <= IDLE;
                cnt_q[p]     <= '0;
                addr_q[p]    <= '0;
                isWrite_q[p] <= 1'b0;
                wrData_q[p]  <= '0;
            end
            numReads_q  <= '0;
            numWrites_q <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                case (state_q[p])
                    IDLE: begin
                        if (reqRead[p] || reqWrite[p]) begin
                            addr_q[p]    <= reqAddr[p];
                            isWrite_q[p] <= reqWrite[p];
                            wrData_q[p]  <= reqData[p];
                            cnt_q[p]     <= LAT;
                            state_q[p]   <= (LAT == 4'd0) ? READY : BUSY;
                        end
                    end
                    BUSY: begin
                        cnt_q[p] <= cnt_q[p] - 4'd1;
                        if (cnt_q[p] == 4'd1) state_q[p] <= READY;
                    end
                    default: state_q[p] <= IDLE;
                endcase
            end
            numReads_q  <= numReads_q + WORD_SIZE'(readInc);
            numWrites_q <= numWrites_q + WORD_SIZE'(writeInc);
        end
    end

    // The data port is written last so it wins a same-index write collision
    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (accessEn[p] && !accessWr[p]) rdData_q[p] <= mem[accessAddr[p]];
        end
        if (accessEn[0] && accessWr[0]) mem[accessAddr[0]] <= accessData[0];
        if (accessEn[1] && accessWr[1]) mem[accessAddr[1]] <= accessData[1];
    end

    assign i_ready    = (state_q[0] == READY);
    assign d_ready    = (state_q[1] == READY);
    assign i_data     = (state_q[0] == READY && !isWrite_q[0]) ? rdData_q[0] : 'z;
    assign d_data     = (state_q[1] == READY && !isWrite_q[1]) ? rdData_q[1] : 'z;
    assign num_reads  = numReads_q;
    assign num_writes = numWrites_q;

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: three instances (latency 2, 0, 3) exercised with a vector
// table, reset-abort and back-to-back sequences, and random dual-port traffic vs a model.
module tb_memory_responder;

    localparam int NINST    = 3;
    localparam int NVEC     = 13;
    localparam int OP_NONE  = 0;
    localparam int OP_READ  = 1;
    localparam int OP_WRITE = 2;

    logic clk = 1'b0;
    logic rstN;
    always #5 clk = ~clk;

    logic        iReadM   [NINST];
    logic        iWriteM  [NINST];
    logic        dReadM   [NINST];
    logic        dWriteM  [NINST];
    logic [15:0] iAddress [NINST];
    logic [15:0] dAddress [NINST];
    logic        iDrvEn   [NINST];
    logic        dDrvEn   [NINST];
    logic [15:0] iDrv     [NINST];
    logic [15:0] dDrv     [NINST];
    logic [15:0] iObs     [NINST];
    logic [15:0] dObs     [NINST];
    logic        iZ       [NINST];
    logic        dZ       [NINST];
    logic        iReady   [NINST];
    logic        dReady   [NINST];
    logic [15:0] numReads [NINST];
    logic [15:0] numWrites[NINST];

    int latOf[NINST] = '{2, 0, 3};

    for (genvar g = 0; g < NINST; g++) begin : gInst
        localparam int LAT = (g == 0) ? 2 : (g == 1) ? 0 : 3;
        wire [15:0] iData;
        wire [15:0] dData;
        assign iData  = iDrvEn[g] ? iDrv[g] : 16'hzzzz;
        assign dData  = dDrvEn[g] ? dDrv[g] : 16'hzzzz;
        assign iObs[g] = iData;
        assign dObs[g] = dData;
        assign iZ[g]   = (iData === 16'hzzzz);
        assign dZ[g]   = (dData === 16'hzzzz);

        memory_responder #(.WORD_SIZE(16), .ADDR_BITS(8), .LATENCY(LAT)) dut (
            .clk       (clk),
            .reset_n   (rstN),
            .i_readM   (iReadM[g]),
            .i_writeM  (iWriteM[g]),
            .i_address (iAddress[g]),
            .i_data    (iData),
            .i_ready   (iReady[g]),
            .d_readM   (dReadM[g]),
            .d_writeM  (dWriteM[g]),
            .d_address (dAddress[g]),
            .d_data    (dData),
            .d_ready   (dReady[g]),
            .num_reads (numReads[g]),
            .num_writes(numWrites[g])
        );
    end

    typedef struct {
        int          inst;
        int          iOp;
        logic [15:0] iAddr;
        logic [15:0] iWd;
        logic [15:0] iExp;
        int          dOp;
        logic [15:0] dAddr;
        logic [15:0] dWd;
        logic [15:0] dExp;
    } vec_t;

    vec_t        vecs[NVEC];
    int          assertCount = 0;
    int          failCount   = 0;
    int          expReads [NINST];
    int          expWrites[NINST];
    logic [15:0] model[256];

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int k, input int port, input int op,
                                 input logic [15:0] addr, input logic [15:0] data);
        if (port == 0) begin
            iReadM[k]   = (op == OP_READ);
            iWriteM[k]  = (op == OP_WRITE);
            iAddress[k] = addr;
            iDrv[k]     = data;
            iDrvEn[k]   = (op == OP_WRITE);
        end else begin
            dReadM[k]   = (op == OP_READ);
            dWriteM[k]  = (op == OP_WRITE);
            dAddress[k] = addr;
            dDrv[k]     = data;
            dDrvEn[k]   = (op == OP_WRITE);
        end
    endtask

    function automatic logic readyOf(input int k, input int p);
        return (p == 0) ? iReady[k] : dReady[k];
    endfunction

    function automatic logic busZ(input int k, input int p);
        return (p == 0) ? iZ[k] : dZ[k];
    endfunction

    function automatic logic [15:0] obsOf(input int k, input int p);
        return (p == 0) ? iObs[k] : dObs[k];
    endfunction

    function automatic logic [15:0] randAddr();
        logic [7:0] hi;
        logic [7:0] lo;
        hi = 8'($urandom);
        lo = 8'h40 + 8'($urandom_range(0, 7));
        return {hi, lo};
    endfunction

    task automatic countOps(input int k, input int iOp, input int dOp);
        if (iOp == OP_READ)  expReads[k]++;
        if (iOp == OP_WRITE) expWrites[k]++;
        if (dOp == OP_READ)  expReads[k]++;
        if (dOp == OP_WRITE) expWrites[k]++;
    endtask

    task automatic checkCounters(input int k, input string tag);
        checkOutput({tag, "_numReads"},  numReads[k],  16'(expReads[k]));
        checkOutput({tag, "_numWrites"}, numWrites[k], 16'(expWrites[k]));
    endtask

    // One request per port starting in the same cycle; cycle numbers count from the request cycle
    task automatic runPair(input int k,
                           input int iOp, input logic [15:0] iAddr, input logic [15:0] iWd,
                           input int dOp, input logic [15:0] dAddr, input logic [15:0] dWd,
                           output logic [15:0] iRd, output logic [15:0] dRd,
                           output int iCyc, output int dCyc);
        int          op  [2];
        int          cyc [2];
        logic [15:0] rd  [2];
        bit          done[2];
        op[0] = iOp;
        op[1] = dOp;
        @(negedge clk);
        applyStimulus(k, 0, iOp, iAddr, iWd);
        applyStimulus(k, 1, dOp, dAddr, dWd);
        for (int p = 0; p < 2; p++) begin
            cyc[p]  = -1;
            rd[p]   = '0;
            done[p] = (op[p] == OP_NONE);
        end
        #1;
        for (int p = 0; p < 2; p++)
            if (op[p] == OP_READ)
                checkOutput($sformatf("inst%0d_p%0d_busIdleCycle0", k, p), 16'(busZ(k, p)), 16'd1);
        for (int c = 1; c <= 40 && !(done[0] && done[1]); c++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                if (!done[p]) begin
                    if (cyc[p] < 0) begin
                        if (readyOf(k, p)) begin
                            cyc[p] = c;
                            rd[p]  = obsOf(k, p);
                        end
                    end else begin
                        checkOutput($sformatf("inst%0d_p%0d_readyOnePulse", k, p), 16'(readyOf(k, p)), 16'd0);
                        if (op[p] == OP_READ)
                            checkOutput($sformatf("inst%0d_p%0d_busReleased", k, p), 16'(busZ(k, p)), 16'd1);
                        applyStimulus(k, p, OP_NONE, 16'h0, 16'h0);
                        done[p] = 1'b1;
                    end
                end
            end
        end
        for (int p = 0; p < 2; p++) begin
            if (!done[p]) begin
                assertCount++;
                failCount++;
                $display("[TB] FAIL inst%0d_p%0d_timeout: got no completed access, expected ready within 40 cycles", k, p);
                applyStimulus(k, p, OP_NONE, 16'h0, 16'h0);
            end
        end
        iRd  = rd[0];
        dRd  = rd[1];
        iCyc = cyc[0];
        dCyc = cyc[1];
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no end of test, expected finish before 500000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] iRd;
        logic [15:0] dRd;
        int          iCyc;
        int          dCyc;
        int          k;
        int          iOp;
        int          dOp;
        logic [15:0] iA;
        logic [15:0] dA;
        logic [15:0] iW;
        logic [15:0] dW;
        logic [15:0] iExpRd;
        logic [15:0] dExpRd;
        bit          sawReady;

        vecs[0]  = '{0, OP_NONE,  16'h0000, 16'h0000, 16'h0000, OP_WRITE, 16'h0010, 16'hBEEF, 16'h0000};
        vecs[1]  = '{0, OP_READ,  16'h0010, 16'h0000, 16'hBEEF, OP_NONE,  16'h0000, 16'h0000, 16'h0000};
        vecs[2]  = '{0, OP_WRITE, 16'h0020, 16'h1111, 16'h0000, OP_WRITE, 16'h0020, 16'h2222, 16'h0000};
        vecs[3]  = '{0, OP_READ,  16'h0020, 16'h0000, 16'h2222, OP_NONE,  16'h0000, 16'h0000, 16'h0000};
        vecs[4]  = '{0, OP_NONE,  16'h0000, 16'h0000, 16'h0000, OP_WRITE, 16'h0030, 16'h00AA, 16'h0000};
        vecs[5]  = '{0, OP_READ,  16'h0030, 16'h0000, 16'h00AA, OP_WRITE, 16'h0030, 16'h00BB, 16'h0000};
        vecs[6]  = '{0, OP_NONE,  16'h0000, 16'h0000, 16'h0000, OP_READ,  16'h0030, 16'h0000, 16'h00BB};
        vecs[7]  = '{0, OP_WRITE, 16'h0107, 16'h5A5A, 16'h0000, OP_NONE,  16'h0000, 16'h0000, 16'h0000};
        vecs[8]  = '{0, OP_NONE,  16'h0000, 16'h0000, 16'h0000, OP_READ,  16'h0007, 16'h0000, 16'h5A5A};
        vecs[9]  = '{1, OP_WRITE, 16'h0005, 16'h1234, 16'h0000, OP_NONE,  16'h0000, 16'h0000, 16'h0000};
        vecs[10] = '{1, OP_READ,  16'h0005, 16'h0000, 16'h1234, OP_NONE,  16'h0000, 16'h0000, 16'h0000};
        vecs[11] = '{2, OP_NONE,  16'h0000, 16'h0000, 16'h0000, OP_WRITE, 16'h0040, 16'hC0DE, 16'h0000};
        vecs[12] = '{2, OP_NONE,  16'h0000, 16'h0000, 16'h0000, OP_READ,  16'h0040, 16'h0000, 16'hC0DE};

        rstN = 1'b0;
        for (int n = 0; n < NINST; n++) begin
            applyStimulus(n, 0, OP_NONE, 16'h0, 16'h0);
            applyStimulus(n, 1, OP_NONE, 16'h0, 16'h0);
            expReads[n]  = 0;
            expWrites[n] = 0;
        end
        repeat (2) @(negedge clk);
        for (int n = 0; n < NINST; n++) begin
            checkOutput($sformatf("reset_inst%0d_iReady", n), 16'(iReady[n]), 16'd0);
            checkOutput($sformatf("reset_inst%0d_dReady", n), 16'(dReady[n]), 16'd0);
            checkOutput($sformatf("reset_inst%0d_iBusZ", n),  16'(iZ[n]), 16'd1);
            checkOutput($sformatf("reset_inst%0d_dBusZ", n),  16'(dZ[n]), 16'd1);
            checkCounters(n, $sformatf("reset_inst%0d", n));
        end
        rstN = 1'b1;

        for (int v = 0; v < NVEC; v++) begin
            k = vecs[v].inst;
            runPair(k, vecs[v].iOp, vecs[v].iAddr, vecs[v].iWd,
                    vecs[v].dOp, vecs[v].dAddr, vecs[v].dWd, iRd, dRd, iCyc, dCyc);
            if (vecs[v].iOp != OP_NONE)
                checkOutput($sformatf("vec%0d_iReadyCycle", v), 16'(iCyc), 16'(latOf[k] + 1));
            if (vecs[v].dOp != OP_NONE)
                checkOutput($sformatf("vec%0d_dReadyCycle", v), 16'(dCyc), 16'(latOf[k] + 1));
            if (vecs[v].iOp == OP_READ)
                checkOutput($sformatf("vec%0d_iData", v), iRd, vecs[v].iExp);
            if (vecs[v].dOp == OP_READ)
                checkOutput($sformatf("vec%0d_dData", v), dRd, vecs[v].dExp);
            countOps(k, vecs[v].iOp, vecs[v].dOp);
            checkCounters(k, $sformatf("vec%0d", v));
        end

        // Reset lands in cycle 2 of a latency-3 read, before its access edge
        @(negedge clk);
        applyStimulus(2, 1, OP_READ, 16'h0040, 16'h0);
        repeat (2) @(negedge clk);
        rstN = 1'b0;
        #1;
        checkOutput("abort_dReadyLow", 16'(dReady[2]), 16'd0);
        checkOutput("abort_dBusZ", 16'(dZ[2]), 16'd1);
        for (int n = 0; n < NINST; n++) begin
            expReads[n]  = 0;
            expWrites[n] = 0;
        end
        checkCounters(2, "abort_inReset");
        @(negedge clk);
        applyStimulus(2, 1, OP_NONE, 16'h0, 16'h0);
        rstN     = 1'b1;
        sawReady = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (dReady[2]) sawReady = 1'b1;
        end
        checkOutput("abort_noReadyPulse", 16'(sawReady), 16'd0);
        checkOutput("abort_dBusZAfter", 16'(dZ[2]), 16'd1);
        checkCounters(2, "abort_after");
        runPair(2, OP_NONE, 16'h0, 16'h0, OP_READ, 16'h0040, 16'h0, iRd, dRd, iCyc, dCyc);
        checkOutput("abort_newReqCycle", 16'(dCyc), 16'd4);
        checkOutput("abort_newReqData", dRd, 16'hC0DE);
        countOps(2, OP_NONE, OP_READ);
        checkCounters(2, "abort_newReq");

        // Zero latency with the request held: a new access every second cycle
        @(negedge clk);
        applyStimulus(1, 0, OP_READ, 16'h0005, 16'h0);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            checkOutput($sformatf("b2b_iReady_c%0d", c), 16'(iReady[1]), 16'(c % 2));
            if (c == 3) checkOutput("b2b_iData_c3", iObs[1], 16'h1234);
        end
        applyStimulus(1, 0, OP_NONE, 16'h0, 16'h0);
        expReads[1] += 2;
        checkCounters(1, "b2b");

        for (int n = 0; n < 4; n++) begin
            iA = 16'(32'h40 + n);
            dA = 16'(32'h44 + n);
            iW = 16'($urandom);
            dW = 16'($urandom);
            runPair(0, OP_WRITE, iA, iW, OP_WRITE, dA, dW, iRd, dRd, iCyc, dCyc);
            checkOutput($sformatf("preload%0d_cycle", n), 16'(iCyc + dCyc), 16'd6);
            model[iA[7:0]] = iW;
            model[dA[7:0]] = dW;
            countOps(0, OP_WRITE, OP_WRITE);
        end
        checkCounters(0, "preload");

        for (int n = 0; n < 60; n++) begin
            iOp = int'($urandom_range(0, 2));
            dOp = int'($urandom_range(0, 2));
            if (iOp == OP_NONE && dOp == OP_NONE) dOp = OP_READ;
            iA     = randAddr();
            dA     = randAddr();
            iW     = 16'($urandom);
            dW     = 16'($urandom);
            iExpRd = model[iA[7:0]];
            dExpRd = model[dA[7:0]];
            runPair(0, iOp, iA, iW, dOp, dA, dW, iRd, dRd, iCyc, dCyc);
            if (iOp != OP_NONE) checkOutput($sformatf("rand%0d_iReadyCycle", n), 16'(iCyc), 16'd3);
            if (dOp != OP_NONE) checkOutput($sformatf("rand%0d_dReadyCycle", n), 16'(dCyc), 16'd3);
            if (iOp == OP_READ) checkOutput($sformatf("rand%0d_iData", n), iRd, iExpRd);
            if (dOp == OP_READ) checkOutput($sformatf("rand%0d_dData", n), dRd, dExpRd);
            if (iOp == OP_WRITE) model[iA[7:0]] = iW;
            if (dOp == OP_WRITE) model[dA[7:0]] = dW;
            countOps(0, iOp, dOp);
            checkCounters(0, $sformatf("rand%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/memory_responder.md
# memory_responder

Dual-port word memory that answers the CPU's instruction and data memory interfaces (readM/writeM, address, bidirectional data) with a configurable access latency and a per-port ready handshake. It is the responder end of the interface the CPU top initiates on, and it replaces the zero-latency testbench memory for the stall-capable pipeline revision. The instruction and data ports share one storage array. Each port runs an independent request/latency/ready state machine.

## Interface
- WORD_SIZE, 16: data and address width.
- ADDR_BITS, 8: array depth is 2^ADDR_BITS words; upper address bits are ignored (aliasing).
- LATENCY, 2: extra wait cycles per access, legal range 0..15.
- clk  input  1  single clock; all state changes on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- i_readM, i_writeM  input  1 each  instruction-port read/write request levels.
- i_address  input  WORD_SIZE  instruction-port word address.
- i_data  inout  WORD_SIZE  instruction-port data; responder drives it only during a read's READY cycle, else high-Z.
- i_ready  output  1  instruction-port completion strobe.
- d_readM, d_writeM, d_address, d_data, d_ready: the same signals for the data port.
- num_reads, num_writes  output  WORD_SIZE each  completed-access counters, both ports summed, wrapping.

## Operation
- Per-port FSM states: IDLE, BUSY, READY.
- IDLE: at a posedge with readM|writeM high, latch the address, the op (writeM has priority if both are high), and the write data. Set cnt=LATENCY.
  - If LATENCY=0: perform the array access at this same edge and go to READY.
  - Otherwise go to BUSY.
- BUSY: each posedge decrements cnt. At the edge where cnt==1, perform the array access and go to READY.
- Array access:
  - Write stores the latched data at latched address[ADDR_BITS-1:0].
  - Read captures the array word into the port's read-data register.
- READY: ready=1 for exactly one cycle. For a read, the port drives its data bus with the captured word. The next posedge returns to IDLE unconditionally. Requests are not sampled during the READY cycle.
- The initiator holds readM/writeM/address/data stable from the request cycle through the READY cycle. It must deassert the request, or present a new one, in the cycle after READY. A request still high in that cycle is taken as a new access.
- Request changes while the port is in BUSY or READY are ignored; the latched values are used.
- Same-edge conflicts, both ports accessing the same array index at one edge:
  - Both write: the data-port value is stored.
  - One writes, one reads: the read returns the old contents.
- Counters increment at the access edge. num_reads counts completed reads and num_writes counts completed writes. If both ports complete at the same edge, the counter adds 2. Counters wrap modulo 2^WORD_SIZE.
- The array is not reset and holds its contents across reset. Its initial contents come from the testbench or an initial load.

## Timing
- Reset (async assertion): both FSMs go to IDLE, i_ready/d_ready=0, both data buses high-Z, num_reads=num_writes=0, cnt=0.
- A reset asserted mid-access aborts the access. If it lands before the access edge, the array is untouched. No READY pulse follows.
- The request is first visible in cycle 0. The access happens at the end of cycle LATENCY. ready is high and read data is valid in cycle LATENCY+1.
- Back-to-back accesses on one port: the request is re-presented in cycle LATENCY+2. One access completes per LATENCY+2 cycles.
- The two ports are fully independent. There is no arbitration stall between them.
- The data bus is driven only while ready=1 on a read. It is released combinationally when the FSM leaves READY.

## Test plan
- LATENCY=2, reset, then a d-port write of 0xBEEF to address 0x0010 (d_writeM=1, held) -> d_ready high in cycle 3 only; num_writes=1; a subsequent i-port read of 0x0010 returns 0xBEEF on i_data in cycle 3 of that request.
- LATENCY=0, i-port read of a preloaded address 0x0005=0x1234 -> i_ready and i_data=0x1234 in cycle 1; i_data is high-Z in cycles 0 and 2.
- LATENCY=2, both ports write address 0x0020 in the same cycle (i:0x1111, d:0x2222) -> both ready in cycle 3; a later read returns 0x2222; num_writes=2.
- LATENCY=2, i-port read of 0x0030 (old 0x00AA) together with a d-port write of 0x00BB to 0x0030 in the same cycle -> i_data=0x00AA; a later read returns 0x00BB.
- LATENCY=3, start a d-port read, pulse reset_n low in cycle 2 -> d_ready never pulses; counters 0; d_data high-Z; port accepts a new request after reset.
- Address aliasing: with ADDR_BITS=8, write 0x5A5A to 0x0107, then read 0x0007 -> returns 0x5A5A.
